// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with a direct-select mode and a
// self-running scan mode that dwells DWELL cycles on each output.
module decoder_scan_nto2n #(
   parameter int N          = 2,
   parameter int DWELL      = 4,
   parameter int ACTIVE_LOW = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [N-1:0]     sel,
   input  logic             sel_valid,
   output logic [2**N-1:0]  dec_out,
   output logic [N-1:0]     cur_idx,
   output logic             out_valid,
   output logic             wrap
);

   localparam int W  = 2**N;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            valid_q, valid_d;
   logic            wrap_q, wrap_d;
   logic [W-1:0]    dec_q, dec_d;
   logic [W-1:0]    onehot;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;
      if (!en) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else if (!mode) begin
         state_d = DIRECT;
         cnt_d   = '0;
         if (sel_valid) begin
            idx_d   = sel;
            valid_d = 1'b1;
         end else if (state_q != DIRECT) begin
            // Entering direct mode without a select leaves the outputs dark.
            idx_d   = '0;
            valid_d = 1'b0;
         end
      end else begin
         state_d = SCAN;
         valid_d = 1'b1;
         if (state_q != SCAN) begin
            idx_d = '0;
            cnt_d = '0;
         end else if (cnt_q == CW'(DWELL - 1)) begin
            cnt_d  = '0;
            idx_d  = idx_q + N'(1);
            wrap_d = (idx_q == {N{1'b1}});
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // The decode is formed from the next index so dec_out stays aligned with cur_idx.
   always_comb begin
      onehot        = '0;
      onehot[idx_d] = 1'b1;
      dec_d         = valid_d ? onehot : '0;
      if (ACTIVE_LOW != 0) begin
         dec_d = ~dec_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         dec_q   <= (ACTIVE_LOW != 0) ? {W{1'b1}} : '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         dec_q   <= dec_d;
      end
   end

   assign dec_out   = dec_q;
   assign cur_idx   = idx_q;
   assign out_valid = valid_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Scoreboard bench: directed vectors push expected outputs, a monitor pops and
// compares one cycle later. Instance A: N=2 DWELL=3; instance B: N=3 DWELL=1 active-low.
module tb_decoder_scan_nto2n;

   typedef struct {
      bit         which;
      logic [7:0] dec;
      logic [2:0] idx;
      logic       valid;
      logic       wrap;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_a, en_a, mode_a, sv_a;
   logic [1:0] sel_a;
   logic [3:0] dec_a;
   logic [1:0] idx_a;
   logic       valid_a, wrap_a;
   logic       rst_b, en_b, mode_b, sv_b;
   logic [2:0] sel_b;
   logic [7:0] dec_b;
   logic [2:0] idx_b;
   logic       valid_b, wrap_b;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   decoder_scan_nto2n #(.N(2), .DWELL(3), .ACTIVE_LOW(0)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .sel(sel_a),
      .sel_valid(sv_a), .dec_out(dec_a), .cur_idx(idx_a),
      .out_valid(valid_a), .wrap(wrap_a)
   );

   decoder_scan_nto2n #(.N(3), .DWELL(1), .ACTIVE_LOW(1)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .sel(sel_b),
      .sel_valid(sv_b), .dec_out(dec_b), .cur_idx(idx_b),
      .out_valid(valid_b), .wrap(wrap_b)
   );

   // Compare one expected entry against whichever instance it belongs to.
   task automatic checkOutput(input exp_t e);
      logic [7:0] d;
      logic [2:0] i;
      logic       v, w;
      if (e.which) begin
         d = dec_b; i = idx_b; v = valid_b; w = wrap_b;
      end else begin
         d = {4'b0, dec_a}; i = {1'b0, idx_a}; v = valid_a; w = wrap_a;
      end
      checks++;
      if (d !== e.dec || i !== e.idx || v !== e.valid || w !== e.wrap) begin
         errors++;
         $display("[TB] FAIL %s: got dec=%b idx=%0d valid=%b wrap=%b, expected dec=%b idx=%0d valid=%b wrap=%b",
                  e.name, d, i, v, w, e.dec, e.idx, e.valid, e.wrap);
      end
   endtask

   // Drive one cycle of inputs on the chosen instance and queue its expected result.
   task automatic applyStimulus(input bit which, input logic r, input logic e,
                                input logic m, input logic [2:0] s, input logic v,
                                input logic [7:0] xdec, input logic [2:0] xidx,
                                input logic xval, input logic xwrap, input string name);
      exp_t x;
      @(negedge clk);
      #1;
      if (which) begin
         rst_b = r; en_b = e; mode_b = m; sel_b = s; sv_b = v;
      end else begin
         rst_a = r; en_a = e; mode_a = m; sel_a = s[1:0]; sv_a = v;
      end
      x.which = which; x.dec = xdec; x.idx = xidx;
      x.valid = xval; x.wrap = xwrap; x.name = name;
      expQ.push_back(x);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
         end
      end
   end

   initial begin : stimulus
      logic [2:0] k3;
      rst_a = 1'b1; en_a = 1'b0; mode_a = 1'b0; sel_a = 2'd0; sv_a = 1'b0;
      rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; sel_b = 3'd0; sv_b = 1'b0;

      applyStimulus(0, 1, 0, 0, 0, 0, 8'b0000, 0, 0, 0, "a_reset0");
      applyStimulus(0, 1, 0, 0, 0, 0, 8'b0000, 0, 0, 0, "a_reset1");
      applyStimulus(0, 0, 0, 0, 0, 0, 8'b0000, 0, 0, 0, "a_idle");

      applyStimulus(0, 0, 1, 0, 0, 1, 8'b0001, 0, 1, 0, "a_direct_sel0");
      applyStimulus(0, 0, 1, 0, 1, 1, 8'b0010, 1, 1, 0, "a_direct_sel1");
      applyStimulus(0, 0, 1, 0, 2, 1, 8'b0100, 2, 1, 0, "a_direct_sel2");
      applyStimulus(0, 0, 1, 0, 3, 1, 8'b1000, 3, 1, 0, "a_direct_sel3");
      applyStimulus(0, 0, 1, 0, 1, 0, 8'b1000, 3, 1, 0, "a_direct_hold");

      // Scan: three cycles per index, wrap on the 12th cycle after entry.
      applyStimulus(0, 0, 1, 1, 2, 1, 8'b0001, 0, 1, 0, "a_scan_entry");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0001, 0, 1, 0, "a_scan_k1");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0001, 0, 1, 0, "a_scan_k2");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0010, 1, 1, 0, "a_scan_k3");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0010, 1, 1, 0, "a_scan_k4");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0010, 1, 1, 0, "a_scan_k5");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0100, 2, 1, 0, "a_scan_k6");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0100, 2, 1, 0, "a_scan_k7");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0100, 2, 1, 0, "a_scan_k8");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b1000, 3, 1, 0, "a_scan_k9");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b1000, 3, 1, 0, "a_scan_k10");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b1000, 3, 1, 0, "a_scan_k11");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0001, 0, 1, 1, "a_scan_wrap");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0001, 0, 1, 0, "a_scan_k13");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0001, 0, 1, 0, "a_scan_k14");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0010, 1, 1, 0, "a_scan_k15");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0010, 1, 1, 0, "a_scan_k16");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0010, 1, 1, 0, "a_scan_k17");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0100, 2, 1, 0, "a_scan_k18");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0100, 2, 1, 0, "a_scan_k19");

      // Mode switch mid-dwell at idx 2, count 1.
      applyStimulus(0, 0, 1, 0, 3, 1, 8'b1000, 3, 1, 0, "a_switch_direct");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0001, 0, 1, 0, "a_rescan_entry");
      for (int k = 1; k <= 9; k++) begin
         applyStimulus(0, 0, 1, 1, 0, 0, 8'(4'b0001 << (k / 3)), 3'(k / 3), 1, 0, "a_rescan_step");
      end
      applyStimulus(0, 1, 1, 1, 0, 0, 8'b0000, 0, 0, 0, "a_midscan_reset");
      applyStimulus(0, 0, 0, 1, 0, 0, 8'b0000, 0, 0, 0, "a_idle_after_rst");

      // Enable drop at idx 2, then restart from 0.
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0001, 0, 1, 0, "a_en_scan_entry");
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(0, 0, 1, 1, 0, 0, 8'(4'b0001 << (k / 3)), 3'(k / 3), 1, 0, "a_en_scan_step");
      end
      applyStimulus(0, 0, 0, 1, 0, 0, 8'b0000, 0, 0, 0, "a_en_drop");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0001, 0, 1, 0, "a_en_restart");
      applyStimulus(0, 0, 1, 1, 0, 0, 8'b0001, 0, 1, 0, "a_en_restart_k1");

      // Direct entry from scan without sel_valid leaves the outputs dark.
      applyStimulus(0, 0, 1, 0, 3, 0, 8'b0000, 0, 0, 0, "a_direct_entry_dark");
      applyStimulus(0, 0, 1, 0, 3, 0, 8'b0000, 0, 0, 0, "a_direct_dark_hold");
      applyStimulus(0, 0, 1, 0, 2, 1, 8'b0100, 2, 1, 0, "a_direct_first_sel");

      // Instance B: active-low, one cycle per index, wrap every 8 cycles.
      applyStimulus(1, 1, 0, 0, 0, 0, 8'hFF, 0, 0, 0, "b_reset");
      applyStimulus(1, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, "b_idle");
      for (int k = 0; k <= 16; k++) begin
         k3 = 3'(k);
         applyStimulus(1, 0, 1, 1, 5, 1, ~(8'b1 << k3), k3, 1,
                       (k == 8 || k == 16), "b_scan");
      end
      applyStimulus(1, 0, 0, 1, 0, 0, 8'hFF, 0, 0, 0, "b_idle_end");

      for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
         @(negedge clk);
         #2;
      end
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_scan_nto2n.md
Name: decoder_scan_nto2n

Overview:
Parametrised, fully registered N-to-2^N one-hot decoder with enable and a second operating mode. In direct mode it decodes a validated select input. In scan mode it walks its own index through every output, holding each for a programmable dwell time. It is the scalable successor to the team's combinational 2-to-4 decoder, for strobe and row/digit scanning logic.

Parameters:
N, 2, select width; output width is 2^N; N >= 1
DWELL, 4, clock cycles each position is held in scan mode; DWELL >= 1
ACTIVE_LOW, 0, 1 = dec_out active-low: selected bit 0, all others 1

Ports:
clk  input  1  system clock; the only clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  block enable
mode  input  1  0 = direct decode, 1 = scan
sel  input  N  select index, used in direct mode only
sel_valid  input  1  sel is valid this cycle (direct mode)
dec_out  output  2^N  registered one-hot (or one-cold) decode
cur_idx  output  N  index currently driven on dec_out
out_valid  output  1  dec_out carries a live selection
wrap  output  1  one-cycle pulse when the scan index wraps 2^N-1 -> 0

Behaviour:
- All outputs registered. "Inactive" dec_out = all 0 (ACTIVE_LOW=0) or all 1 (ACTIVE_LOW=1).
- Reset (rst=1 at an edge, priority over everything): state IDLE, dec_out inactive, cur_idx 0, out_valid 0, wrap 0, dwell counter 0. A mid-scan reset takes effect on the next edge with no partial outputs.
- States: IDLE, DIRECT, SCAN. The next state is evaluated every cycle:
  - en=0 -> IDLE.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN.
- IDLE: dec_out inactive, out_valid 0, cur_idx 0, dwell counter 0, wrap 0.
- DIRECT, on an edge with sel_valid=1: dec_out one-hot at sel, cur_idx=sel, out_valid=1. Latency is 1 cycle from sel_valid to dec_out.
- DIRECT, sel_valid=0: all outputs hold.
- DIRECT, entry from IDLE or SCAN without sel_valid on the entry edge: dec_out inactive, out_valid 0 until the first sel_valid.
- DIRECT: wrap is always 0.
- SCAN entry (edge where the state becomes SCAN from IDLE or DIRECT): cur_idx=0, dec_out one-hot bit 0, out_valid=1, dwell counter 0. sel and sel_valid are ignored.
- SCAN, each further edge:
  - If dwell counter = DWELL-1: counter -> 0 and cur_idx -> cur_idx+1 modulo 2^N, with dec_out following.
  - Otherwise the counter increments.
  - With DWELL=1 the index advances every cycle.
- wrap=1 for exactly the one cycle in which cur_idx has just changed from 2^N-1 to 0. It is not asserted on SCAN entry.
- Mode change while en=1 takes effect on the next edge, per the entry rules above. Dwell progress is discarded.
- en falling mid-scan: next edge goes to IDLE. Re-enabling restarts the scan from index 0.
- Dwell counter width is $clog2(DWELL), minimum 1 bit.
- dec_out always has exactly one active bit when out_valid=1, and none when out_valid=0.

Test Plan:
- N=2, DWELL=3. rst high for 2 cycles, then low with en=0 -> dec_out=0000, cur_idx=0, out_valid=0, wrap=0.
- Direct mode, N=2: en=1, mode=0, drive sel=0..3 with sel_valid=1 for one cycle each -> one cycle later dec_out = 0001, 0010, 0100, 1000 in turn. Then sel_valid=0 with sel=1 -> dec_out holds 1000.
- Scan mode, N=2, DWELL=3: en=1, mode=1 -> dec_out=0001 for 3 cycles, then 0010, 0100 and 1000 for 3 cycles each, then 0001 again. wrap=1 only on the first cycle of the return to 0001 (cycle 12 after entry).
- Mode switch mid-dwell: in scan at cur_idx=2 with dwell count 1, set mode=0 with sel=3, sel_valid=1 -> next cycle dec_out=1000, cur_idx=3, wrap=0. Set mode=1 again -> scan restarts at 0001.
- Reset/enable mid-operation: during scan at cur_idx=3, pulse rst for 1 cycle -> next edge dec_out=0000, out_valid=0. Separately, drop en at cur_idx=2 -> IDLE next edge; re-raise en -> restart at 0001.
- ACTIVE_LOW=1, N=3, DWELL=1: scan mode -> dec_out steps 11111110, 11111101, ... 01111111 once per cycle. wrap pulses every 8 cycles. IDLE gives 11111111.
